// File: rtl/mem_line_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_arbiter_if
// Brief    : I-side, D-side and memory-side line bus bundle for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_line_arbiter_if #(
    parameter int WORD_SIZE = 16,
    parameter int LINE_SIZE = 64
);
    logic                 i_readM;
    logic [WORD_SIZE-1:0] i_address;
    logic [LINE_SIZE-1:0] i_rdata;
    logic                 i_valid;

    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [LINE_SIZE-1:0] d_wdata;
    logic [LINE_SIZE-1:0] d_rdata;
    logic                 d_valid;

    logic                 m_readM;
    logic                 m_writeM;
    logic [WORD_SIZE-1:0] m_address;
    logic [LINE_SIZE-1:0] m_wdata;
    logic [LINE_SIZE-1:0] m_rdata;
    logic                 m_valid;

    logic                 grant_i;
    logic                 grant_d;

    // Arbiter view
    modport slave (
        input  i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata, m_valid,
        output i_rdata, i_valid, d_rdata, d_valid, m_readM, m_writeM, m_address, m_wdata,
               grant_i, grant_d
    );

    // Requesters plus memory view
    modport master (
        output i_readM, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata, m_valid,
        input  i_rdata, i_valid, d_rdata, d_valid, m_readM, m_writeM, m_address, m_wdata,
               grant_i, grant_d
    );
endinterface
`default_nettype wire

// File: rtl/mem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_line_arbiter
// Brief    : Shares one line-wide memory port between I-cache and D-cache.
// Revision : 1.0 - initial release
// ============================================================================
module mem_line_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int LINE_SIZE    = 64,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_line_arbiter_if.slave bus
);
    localparam int                    c_STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_STREAK_W-1:0] r_d_streak;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_i_done;
    logic                  w_d_done;
    logic                  w_m_readM;
    logic                  w_m_writeM;
    logic [WORD_SIZE-1:0]  w_m_address;
    logic [LINE_SIZE-1:0]  w_m_wdata;
    logic [LINE_SIZE-1:0]  w_i_rdata;
    logic [LINE_SIZE-1:0]  w_d_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_d_streak <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_i_done) begin
                r_d_streak <= '0;
            end else if (w_d_done) begin
                // Streak only grows while I is actually waiting behind D
                if (!w_i_req) begin
                    r_d_streak <= '0;
                end else if (r_d_streak < c_STREAK_MAX) begin
                    r_d_streak <= r_d_streak + c_STREAK_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_i_req      = bus.i_readM;
        w_d_req      = bus.d_readM | bus.d_writeM;
        w_next_state = r_state;
        w_i_done     = 1'b0;
        w_d_done     = 1'b0;
        w_m_readM    = 1'b0;
        w_m_writeM   = 1'b0;
        w_m_address  = '0;
        w_m_wdata    = '0;
        w_i_rdata    = '0;
        w_d_rdata    = '0;

        // Outputs held quiet while in reset so an in-flight result is dropped
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_d_req && (!w_i_req || (r_d_streak < c_STREAK_MAX))) begin
                        w_next_state = S_GNT_D;
                    end else if (w_i_req) begin
                        w_next_state = S_GNT_I;
                    end
                end
                S_GNT_I: begin
                    w_m_readM   = bus.i_readM;
                    w_m_address = bus.i_address;
                    if (bus.m_valid) begin
                        w_i_done     = 1'b1;
                        w_i_rdata    = bus.m_rdata;
                        w_next_state = S_IDLE;
                    end
                end
                S_GNT_D: begin
                    // Simultaneous read and write resolves to a write
                    w_m_writeM  = bus.d_writeM;
                    w_m_readM   = bus.d_readM & ~bus.d_writeM;
                    w_m_address = bus.d_address;
                    w_m_wdata   = bus.d_wdata;
                    if (bus.m_valid) begin
                        w_d_done     = 1'b1;
                        w_d_rdata    = bus.m_rdata;
                        w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_readM   = w_m_readM;
    assign bus.m_writeM  = w_m_writeM;
    assign bus.m_address = w_m_address;
    assign bus.m_wdata   = w_m_wdata;
    assign bus.i_valid   = w_i_done;
    assign bus.i_rdata   = w_i_rdata;
    assign bus.d_valid   = w_d_done;
    assign bus.d_rdata   = w_d_rdata;
    assign bus.grant_i   = (r_state == S_GNT_I);
    assign bus.grant_d   = (r_state == S_GNT_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_line_arbiter
// Brief    : Directed scenarios plus randomized traffic against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_line_arbiter;
    localparam int WORD_SIZE    = 16;
    localparam int LINE_SIZE    = 64;
    localparam int MAX_D_STREAK = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mem_line_arbiter_if #(.WORD_SIZE(WORD_SIZE), .LINE_SIZE(LINE_SIZE)) bus ();

    mem_line_arbiter #(
        .WORD_SIZE    (WORD_SIZE),
        .LINE_SIZE    (LINE_SIZE),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.i_readM   = 1'b0;
        bus.i_address = '0;
        bus.d_readM   = 1'b0;
        bus.d_writeM  = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        bus.m_rdata   = '0;
        bus.m_valid   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        settle();
        n_cmp++;
        if ({bus.m_readM, bus.m_writeM, bus.i_valid, bus.d_valid, bus.grant_i, bus.grant_d} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 000000",
                     {bus.m_readM, bus.m_writeM, bus.i_valid, bus.d_valid, bus.grant_i, bus.grant_d});
        end
        n_cmp++;
        if ({bus.m_address, bus.m_wdata, bus.i_rdata, bus.d_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_buses: addr %h wdata %h irdata %h drdata %h expected all 0",
                     bus.m_address, bus.m_wdata, bus.i_rdata, bus.d_rdata);
        end
    endtask

    task automatic test_i_read();
        logic [LINE_SIZE-1:0] line;
        line = 64'hA5A5_0000_1234_5678;
        tick();
        bus.i_readM   = 1'b1;
        bus.i_address = 16'h0010;
        settle();
        n_cmp++;
        if (bus.m_readM !== 1'b0) begin
            n_err++;
            $display("FAIL iread_latency: m_readM got %b expected 0", bus.m_readM);
        end
        tick();
        settle();
        n_cmp++;
        if ({bus.grant_i, bus.m_readM, bus.m_writeM, bus.m_address, bus.m_wdata} !==
            {1'b1, 1'b1, 1'b0, 16'h0010, 64'h0}) begin
            n_err++;
            $display("FAIL iread_grant: gi %b rd %b wr %b addr %h wdata %h expected 1 1 0 0010 0",
                     bus.grant_i, bus.m_readM, bus.m_writeM, bus.m_address, bus.m_wdata);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            settle();
            n_cmp++;
            if (bus.i_valid !== 1'b0) begin
                n_err++;
                $display("FAIL iread_wait: i_valid got %b expected 0", bus.i_valid);
            end
        end
        tick();
        bus.m_valid = 1'b1;
        bus.m_rdata = line;
        settle();
        n_cmp++;
        if ({bus.i_valid, bus.i_rdata, bus.d_valid, bus.d_rdata} !== {1'b1, line, 1'b0, 64'h0}) begin
            n_err++;
            $display("FAIL iread_done: iv %b ird %h dv %b drd %h expected 1 %h 0 0",
                     bus.i_valid, bus.i_rdata, bus.d_valid, bus.d_rdata, line);
        end
        tick();
        bus.m_valid = 1'b0;
        bus.i_readM = 1'b0;
        settle();
        n_cmp++;
        if ({bus.grant_i, bus.i_valid, bus.m_readM, bus.i_rdata} !== {3'b000, 64'h0}) begin
            n_err++;
            $display("FAIL iread_idle: gi %b iv %b rd %b ird %h expected all 0",
                     bus.grant_i, bus.i_valid, bus.m_readM, bus.i_rdata);
        end
    endtask

    task automatic test_d_write();
        logic [LINE_SIZE-1:0] rd;
        rd = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        bus.d_writeM  = 1'b1;
        bus.d_address = 16'h0020;
        bus.d_wdata   = 64'h1122_3344_5566_7788;
        tick();
        settle();
        n_cmp++;
        if ({bus.grant_d, bus.m_writeM, bus.m_readM, bus.m_address, bus.m_wdata} !==
            {1'b1, 1'b1, 1'b0, 16'h0020, 64'h1122_3344_5566_7788}) begin
            n_err++;
            $display("FAIL dwrite_grant: gd %b wr %b rd %b addr %h wdata %h expected 1 1 0 0020 1122334455667788",
                     bus.grant_d, bus.m_writeM, bus.m_readM, bus.m_address, bus.m_wdata);
        end
        tick();
        bus.m_valid = 1'b1;
        bus.m_rdata = rd;
        settle();
        n_cmp++;
        if ({bus.d_valid, bus.i_valid, bus.d_rdata, bus.i_rdata} !== {1'b1, 1'b0, rd, 64'h0}) begin
            n_err++;
            $display("FAIL dwrite_done: dv %b iv %b drd %h ird %h expected 1 0 %h 0",
                     bus.d_valid, bus.i_valid, bus.d_rdata, bus.i_rdata, rd);
        end
        tick();
        bus.m_valid  = 1'b0;
        bus.d_writeM = 1'b0;
        settle();
        n_cmp++;
        if ({bus.d_valid, bus.i_valid, bus.grant_d, bus.m_writeM} !== 4'b0) begin
            n_err++;
            $display("FAIL dwrite_idle: dv %b iv %b gd %b wr %b expected 0000",
                     bus.d_valid, bus.i_valid, bus.grant_d, bus.m_writeM);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        bus.i_readM   = 1'b1;
        bus.i_address = 16'h0030;
        bus.d_readM   = 1'b1;
        bus.d_address = 16'h0040;
        tick();
        settle();
        n_cmp++;
        if ({bus.grant_d, bus.grant_i, bus.m_address} !== {2'b10, 16'h0040}) begin
            n_err++;
            $display("FAIL simul_d_first: gd %b gi %b addr %h expected 1 0 0040",
                     bus.grant_d, bus.grant_i, bus.m_address);
        end
        tick();
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'h1;
        settle();
        tick();
        bus.m_valid = 1'b0;
        bus.d_readM = 1'b0;
        settle();
        n_cmp++;
        if ({bus.grant_d, bus.grant_i, bus.m_readM} !== 3'b000) begin
            n_err++;
            $display("FAIL simul_bubble: gd %b gi %b rd %b expected 000",
                     bus.grant_d, bus.grant_i, bus.m_readM);
        end
        tick();
        settle();
        n_cmp++;
        if ({bus.grant_i, bus.m_readM, bus.m_address} !== {2'b11, 16'h0030}) begin
            n_err++;
            $display("FAIL simul_i_second: gi %b rd %b addr %h expected 1 1 0030",
                     bus.grant_i, bus.m_readM, bus.m_address);
        end
        tick();
        bus.m_valid = 1'b1;
        settle();
        tick();
        bus.m_valid = 1'b0;
        bus.i_readM = 1'b0;
        settle();
    endtask

    task automatic test_streak();
        int  d_grants;
        bit  i_done;
        i_done   = 1'b0;
        d_grants = 0;
        tick();
        bus.i_readM   = 1'b1;
        bus.i_address = 16'h0100;
        bus.d_readM   = 1'b1;
        bus.d_address = 16'h0200;
        for (int k = 0; k < 40 && !i_done; k++) begin
            tick();
            bus.m_valid = bus.grant_i | bus.grant_d;
            bus.m_rdata = {$urandom(), $urandom()};
            settle();
            if (bus.d_valid) d_grants++;
            if (bus.i_valid) i_done = 1'b1;
        end
        n_cmp++;
        if (!i_done || d_grants != MAX_D_STREAK) begin
            n_err++;
            $display("FAIL streak_limit: i_done %0d d_grants %0d expected 1 %0d", i_done, d_grants, MAX_D_STREAK);
        end
        tick();
        bus.m_valid = 1'b0;
        settle();
        tick();
        settle();
        n_cmp++;
        if ({bus.grant_d, bus.grant_i} !== 2'b10) begin
            n_err++;
            $display("FAIL streak_cleared: gd %b gi %b expected 1 0", bus.grant_d, bus.grant_i);
        end
        tick();
        bus.m_valid = 1'b1;
        settle();
        tick();
        bus.m_valid = 1'b0;
        bus.d_readM = 1'b0;
        bus.i_readM = 1'b0;
        settle();
        tick();
        settle();
    endtask

    task automatic test_reset_mid_grant();
        int pulses;
        pulses = 0;
        tick();
        bus.d_readM   = 1'b1;
        bus.d_address = 16'h0050;
        tick();
        settle();
        n_cmp++;
        if (bus.grant_d !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_grant: gd got %b expected 1", bus.grant_d);
        end
        tick();
        reset       = 1'b1;
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'h5555;
        settle();
        if (bus.d_valid) pulses++;
        tick();
        reset       = 1'b0;
        bus.m_valid = 1'b0;
        bus.d_readM = 1'b0;
        settle();
        n_cmp++;
        if ({bus.grant_d, bus.m_readM, bus.m_writeM, bus.m_address} !== {3'b000, 16'h0}) begin
            n_err++;
            $display("FAIL rstmid_idle: gd %b rd %b wr %b addr %h expected 0 0 0 0000",
                     bus.grant_d, bus.m_readM, bus.m_writeM, bus.m_address);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            settle();
            if (bus.d_valid) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL rstmid_no_valid: d_valid pulses %0d expected 0", pulses);
        end
    endtask

    task automatic test_idle_mvalid_rw();
        tick();
        bus.m_valid = 1'b1;
        bus.m_rdata = 64'h7777;
        settle();
        n_cmp++;
        if ({bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata} !== {2'b00, 128'h0}) begin
            n_err++;
            $display("FAIL idle_mvalid: iv %b dv %b ird %h drd %h expected 0 0 0 0",
                     bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata);
        end
        tick();
        bus.m_valid   = 1'b0;
        bus.d_readM   = 1'b1;
        bus.d_writeM  = 1'b1;
        bus.d_address = 16'h0060;
        bus.d_wdata   = 64'hCAFE_F00D_0000_0001;
        settle();
        n_cmp++;
        if ({bus.grant_i, bus.grant_d} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_stays: gi %b gd %b expected 0 0", bus.grant_i, bus.grant_d);
        end
        tick();
        settle();
        n_cmp++;
        if ({bus.grant_d, bus.m_writeM, bus.m_readM, bus.m_wdata} !== {3'b110, 64'hCAFE_F00D_0000_0001}) begin
            n_err++;
            $display("FAIL rw_is_write: gd %b wr %b rd %b wdata %h expected 1 1 0 cafef00d00000001",
                     bus.grant_d, bus.m_writeM, bus.m_readM, bus.m_wdata);
        end
        tick();
        bus.m_valid = 1'b1;
        settle();
        n_cmp++;
        if (bus.d_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rw_done: d_valid got %b expected 1", bus.d_valid);
        end
        tick();
        bus.m_valid  = 1'b0;
        bus.d_readM  = 1'b0;
        bus.d_writeM = 1'b0;
        settle();
    endtask

    // Random traffic: owner 0=none 1=I 2=D; requesters hold until valid, drop one cycle.
    task automatic test_random();
        int owner, lat, streak, op;
        bit i_busy, d_busy, i_drop, d_drop, ireq, dreq;
        logic                 e_rd, e_wr, e_iv, e_dv;
        logic [WORD_SIZE-1:0] e_addr;
        logic [LINE_SIZE-1:0] e_wdata, e_ird, e_drd;
        owner  = 0;
        lat    = 0;
        streak = 0;
        i_busy = 1'b0;
        d_busy = 1'b0;
        i_drop = 1'b0;
        d_drop = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (i_drop) begin
                bus.i_readM = 1'b0;
                i_busy      = 1'b0;
            end else if (!i_busy && ($urandom_range(0, 2) == 0)) begin
                bus.i_readM   = 1'b1;
                bus.i_address = WORD_SIZE'($urandom());
                i_busy        = 1'b1;
            end
            if (d_drop) begin
                bus.d_readM  = 1'b0;
                bus.d_writeM = 1'b0;
                d_busy       = 1'b0;
            end else if (!d_busy && ($urandom_range(0, 1) == 0)) begin
                op            = int'($urandom_range(0, 2));
                bus.d_readM   = (op != 1);
                bus.d_writeM  = (op != 0);
                bus.d_address = WORD_SIZE'($urandom());
                bus.d_wdata   = {$urandom(), $urandom()};
                d_busy        = 1'b1;
            end
            bus.m_rdata = {$urandom(), $urandom()};
            bus.m_valid = (owner != 0) ? (lat == 0) : ($urandom_range(0, 7) == 0);
            settle();

            e_rd    = (owner == 1) ? bus.i_readM : (owner == 2) ? (bus.d_readM & ~bus.d_writeM) : 1'b0;
            e_wr    = (owner == 2) ? bus.d_writeM : 1'b0;
            e_addr  = (owner == 1) ? bus.i_address : (owner == 2) ? bus.d_address : '0;
            e_wdata = (owner == 2) ? bus.d_wdata : '0;
            e_iv    = (owner == 1) && bus.m_valid;
            e_dv    = (owner == 2) && bus.m_valid;
            e_ird   = e_iv ? bus.m_rdata : '0;
            e_drd   = e_dv ? bus.m_rdata : '0;

            n_cmp++;
            if ({bus.grant_i, bus.grant_d} !== {owner == 1, owner == 2}) begin
                n_err++;
                $display("FAIL rnd_grant cyc %0d: gi/gd %b%b expected owner %0d", cyc, bus.grant_i, bus.grant_d, owner);
            end
            n_cmp++;
            if ({bus.m_readM, bus.m_writeM, bus.m_address, bus.m_wdata} !== {e_rd, e_wr, e_addr, e_wdata}) begin
                n_err++;
                $display("FAIL rnd_mem cyc %0d: rd %b wr %b addr %h wdata %h expected %b %b %h %h",
                         cyc, bus.m_readM, bus.m_writeM, bus.m_address, bus.m_wdata, e_rd, e_wr, e_addr, e_wdata);
            end
            n_cmp++;
            if ({bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata} !== {e_iv, e_dv, e_ird, e_drd}) begin
                n_err++;
                $display("FAIL rnd_resp cyc %0d: iv %b dv %b ird %h drd %h expected %b %b %h %h",
                         cyc, bus.i_valid, bus.d_valid, bus.i_rdata, bus.d_rdata, e_iv, e_dv, e_ird, e_drd);
            end

            ireq   = bus.i_readM;
            dreq   = bus.d_readM | bus.d_writeM;
            i_drop = e_iv;
            d_drop = e_dv;
            if (owner == 0) begin
                if (dreq && (!ireq || streak < MAX_D_STREAK)) owner = 2;
                else if (ireq)                                owner = 1;
                lat = int'($urandom_range(0, 3));
            end else if (bus.m_valid) begin
                if (owner == 1)  streak = 0;
                else if (!ireq)  streak = 0;
                else             streak = (streak + 1 > MAX_D_STREAK) ? MAX_D_STREAK : streak + 1;
                owner = 0;
            end else begin
                lat = lat - 1;
            end
        end
        tick();
        bus.i_readM  = 1'b0;
        bus.d_readM  = 1'b0;
        bus.d_writeM = 1'b0;
        bus.m_valid  = 1'b0;
        settle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_i_read();
        test_d_write();
        test_simultaneous();
        test_streak();
        test_reset_mid_grant();
        test_idle_mvalid_rw();
        test_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
